// File: rtl/mc_arith_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_arith_ctrl_if
// Brief    : Request, unit and response signal bundle for mc_arith_ctrl.
//            master = sequencer side, slave = command source / unit cluster.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_arith_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_opcode;
  logic [3:0]  req_a;
  logic [3:0]  req_b;
  logic [1:0]  sel;
  logic [3:0]  op_a;
  logic [3:0]  op_b;
  logic [3:0]  unit_start;
  logic [3:0]  unit_done;
  logic [31:0] unit_res;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic [1:0]  rsp_opcode;
  logic        rsp_err;

  modport master (
    input  req_valid, req_opcode, req_a, req_b, unit_done, unit_res, rsp_ready,
    output req_ready, sel, op_a, op_b, unit_start, rsp_valid, rsp_result,
           rsp_opcode, rsp_err
  );

  modport slave (
    output req_valid, req_opcode, req_a, req_b, unit_done, unit_res, rsp_ready,
    input  req_ready, sel, op_a, op_b, unit_start, rsp_valid, rsp_result,
           rsp_opcode, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mc_arith_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_arith_ctrl
// Brief    : One-at-a-time sequencer for four multicycle arithmetic units:
//            route operands, pulse start, await done, return the result.
//            Optional macro MC_ARITH_CTRL_TIMEOUT_EN adds a hung-unit timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mc_arith_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mc_arith_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [1:0]  r_sel;
  logic [3:0]  r_op_a;
  logic [3:0]  r_op_b;
  logic [7:0]  r_rsp_result;
  logic [1:0]  r_rsp_opcode;

  logic        w_accept;
  logic        w_done_sel;
  logic        w_timeout;
  logic [7:0]  w_res_sel;
  logic        w_req_ready;
  logic        w_rsp_valid;
  logic [3:0]  w_unit_start;

  // Only the addressed unit's done/result is looked at; other units are mute.
  assign w_accept   = (r_state == S_IDLE) && bus.req_valid;
  assign w_done_sel = bus.unit_done[r_sel];
  assign w_res_sel  = bus.unit_res[{r_sel, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_unit_start = 4'b0000;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_unit_start = 4'b0001 << r_sel;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_sel || w_timeout) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand routing is frozen from one accept to the next so the demuxes
  // see stable inputs for the whole operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel  <= 2'd0;
      r_op_a <= 4'd0;
      r_op_b <= 4'd0;
    end else if (w_accept) begin
      r_sel  <= bus.req_opcode;
      r_op_a <= bus.req_a;
      r_op_b <= bus.req_b;
    end
  end

  // A timeout loads a zero result; an honoured done always takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_result <= 8'h00;
      r_rsp_opcode <= 2'd0;
    end else if (r_state == S_WAIT) begin
      if (w_done_sel) begin
        r_rsp_result <= w_res_sel;
        r_rsp_opcode <= r_sel;
      end else if (w_timeout) begin
        r_rsp_result <= 8'h00;
        r_rsp_opcode <= r_sel;
      end
    end
  end

`ifdef MC_ARITH_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_rsp_err;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (r_state == S_WAIT) && !w_done_sel &&
                     (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT) && !w_done_sel) begin
      r_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_err <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (w_done_sel) begin
        r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready  = w_req_ready;
  assign bus.sel        = r_sel;
  assign bus.op_a       = r_op_a;
  assign bus.op_b       = r_op_b;
  assign bus.unit_start = w_unit_start;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_opcode = r_rsp_opcode;

endmodule
`default_nettype wire

// File: doc/mc_arith_ctrl.md
# mc_arith_ctrl

Sequencer for the multicycle arithmetic datapath: it accepts one operation request at a time and drives the operand-routing select lines toward one of four arithmetic units. It pulses that unit's start, waits for its done, captures the 8-bit result and returns it on a valid/ready response channel. It sits between the command source and the demux/unit cluster and is the only master of the unit start lines.

## Interface

- TIMEOUT_CYCLES, 64, maximum WAIT cycles before a unit is declared hung (only used with MC_ARITH_CTRL_TIMEOUT_EN)
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_opcode  in  2  target unit 0..3
- req_a  in  4  operand A
- req_b  in  4  operand B
- sel  out  2  routing select to the operand demuxes
- op_a  out  4  latched operand A to the demux data input
- op_b  out  4  latched operand B to the demux data input
- unit_start  out  4  one-hot start pulse, bit n = unit n
- unit_done  in  4  per-unit completion, bit n = unit n
- unit_res  in  32  unit results, unit n on bits [8n+7:8n]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  8  captured result
- rsp_opcode  out  2  opcode of the completed request
- rsp_err  out  1  1 = timed out, result invalid

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, latch opcode/a/b into sel/op_a/op_b and go to ISSUE. No other state accepts requests.
- ISSUE: unit_start = 1<<sel for exactly one cycle; clear the timeout counter; go to WAIT. unit_done is ignored in this cycle.
- WAIT: only unit_done[sel] is honoured. Done bits of other units are ignored.
  - When unit_done[sel]=1, capture unit_res[8*sel+:8] into rsp_result, set rsp_err=0 and go to RESP.
- RESP: rsp_valid=1 and rsp_result, rsp_opcode and rsp_err are held stable. When rsp_ready=1, go to IDLE.
- sel, op_a and op_b hold from the accepting edge until the next accept, so the demux inputs never glitch mid-operation.
- Reset (any state, any time): state=IDLE; req_ready=1; sel=0, op_a=0, op_b=0; unit_start=0; rsp_valid=0, rsp_result=0, rsp_opcode=0, rsp_err=0; counter=0. An in-flight operation is abandoned. A late unit_done after reset is ignored because the FSM is in IDLE.

## Timing

- Accept edge (req_valid & req_ready) is cycle 0. ISSUE is cycle 1, with unit_start high during cycle 1.
- The earliest honoured unit_done is in cycle 2. In that case rsp_valid rises in cycle 3.
- Latency from accept to rsp_valid is 3 + (cycles unit_done is late beyond cycle 2).
- A response handshake in cycle N gives req_ready=1 in cycle N+1. Back-to-back throughput is one operation per 4 cycles minimum.
- req_ready is a registered state decode with no combinational path from req_valid. rsp_valid likewise has no combinational path from rsp_ready.
- unit_done held high across operations does not double-complete, because it is sampled only in WAIT.

## Configuration

- MC_ARITH_CTRL_TIMEOUT_EN defined:
  - The counter increments each WAIT cycle without an honoured done.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to RESP with rsp_err=1 and rsp_result=8'h00.
  - If done and timeout fall in the same cycle, done wins (rsp_err=0).
- Not defined: no counter is built, WAIT waits indefinitely, rsp_err is tied to 0 and TIMEOUT_CYCLES is unused.

## Test plan

- Reset mid-WAIT: opcode 2 accepted, rst pulsed in cycle 3 -> all outputs at reset values, req_ready=1; a later unit_done[2]=1 causes no response.
- Basic op: req opcode=1, a=4'h3, b=4'h5; unit_done[1] in cycle 2 with unit_res[15:8]=8'h0F -> unit_start=4'b0010 in cycle 1 only; rsp_valid in cycle 3 with rsp_result=8'h0F, rsp_opcode=1, rsp_err=0.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0 and a new req_valid is not accepted; rsp_ready=1 -> IDLE next cycle.
- Wrong-unit done: opcode 3 in flight, unit_done=4'b0001 with unit_res[7:0]=8'hAA -> ignored; unit_done[3] with 8'h42 -> rsp_result=8'h42.
- Timeout (macro on, TIMEOUT_CYCLES=4): opcode 0 and no done -> rsp_valid with rsp_err=1, rsp_result=8'h00; with macro off the FSM stays in WAIT for 100 cycles.
- Back-to-back: two requests with rsp_ready tied 1 and done in cycle 2 -> second accept exactly 4 cycles after the first, with sel updated only at the second accept.
